// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: Fibonacci LFSR whose state is streamed out as valid/ready
// bursts, either of a fixed beat count or free-running until a stop request.
module lfsr_stream_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0] SEED      = 8'h01,
  parameter int               LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  input  logic                 stop,
  output logic [WIDTH-1:0]     m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  fsm_t                 state_q;
  fsm_t                 state_d;
  logic [WIDTH-1:0]     lfsr_q;
  logic [WIDTH-1:0]     lfsr_shift;
  logic [WIDTH-1:0]     seed_fix;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic [LEN_WIDTH-1:0] len_m1;
  logic                 free_run;
  logic                 stop_pending;
  logic                 stop_now;
  logic                 tlast_q;
  logic                 done_q;
  logic                 handshake;

  // The beat on the bus is the LFSR state itself; valid simply means "in RUN".
  assign m_tdata   = lfsr_q;
  assign m_tvalid  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign m_tlast   = tlast_q;
  assign done      = done_q;
  assign handshake = m_tvalid & m_tready;

  // Left-shifting Fibonacci step; an all-zero seed would lock up, so swap in SEED.
  assign lfsr_shift = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign seed_fix   = (seed_in == '0) ? SEED : seed_in;

  // cnt_inc is the number of handshakes including the one happening now; the
  // next beat is the last when that equals len-1, so len = 2^LEN_WIDTH-1 never wraps.
  assign cnt_inc  = beat_cnt + 1'b1;
  assign len_m1   = len_q - 1'b1;

  // A stop only matters in free-run while the presented beat is not yet final.
  assign stop_now = free_run & ~tlast_q & stop;

  // State register for the IDLE/RUN controller.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: leave IDLE on start, return once the tlast beat is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (handshake && tlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: LFSR, beat counter, stop latch, tlast and done pulse; tlast only
  // changes on a handshake so it stays put across any stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q       <= SEED;
      beat_cnt     <= '0;
      len_q        <= '0;
      free_run     <= 1'b0;
      stop_pending <= 1'b0;
      tlast_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seed_load) lfsr_q <= seed_fix;
          if (start) begin
            beat_cnt     <= '0;
            len_q        <= burst_len;
            free_run     <= (burst_len == '0);
            stop_pending <= 1'b0;
            tlast_q      <= (burst_len == {{(LEN_WIDTH-1){1'b0}}, 1'b1});
          end
        end
        RUN: begin
          if (stop_now) stop_pending <= 1'b1;
          if (handshake) begin
            lfsr_q <= lfsr_shift;
            if (tlast_q) begin
              tlast_q      <= 1'b0;
              stop_pending <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              beat_cnt <= cnt_inc;
              if (free_run) tlast_q <= stop_pending | stop_now;
              else          tlast_q <= (cnt_inc == len_m1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb_lfsr_stream_gen: directed scenarios plus random traffic for lfsr_stream_gen,
// checked every cycle against a beat-level reference model.
module tb_lfsr_stream_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_load;
  logic [7:0]  seed_in;
  logic        start;
  logic [15:0] burst_len;
  logic        stop;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  // Reference model: current sequence value, whether a burst is active, beats
  // still owed in a counted burst, and whether the presented beat is the last.
  logic [7:0] mState = 8'h01;
  bit         mActive = 0;
  bit         mFree = 0;
  bit         mFinal = 0;
  bit         mStopReq = 0;
  bit         mDone = 0;
  int         mRemaining = 0;

  logic [8:0] beats[$];
  logic [8:0] expBeats[$];

  lfsr_stream_gen dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .burst_len(burst_len), .stop(stop),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Next sequence value: double modulo 256, add the parity of the tapped bits.
  function automatic logic [7:0] lfsrNext(input logic [7:0] s);
    int fb;
    int v;
    fb = $countones(s & 8'hB8) % 2;
    v  = ((int'(s) * 2) % 256) + fb;
    return v[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelUpdate();
    bit hs;
    hs    = mActive && m_tready;
    mDone = 0;
    if (reset) begin
      mState = 8'h01; mActive = 0; mFinal = 0; mStopReq = 0;
    end else if (!mActive) begin
      if (seed_load) mState = (seed_in == 8'h00) ? 8'h01 : seed_in;
      if (start) begin
        mActive = 1; mFree = (burst_len == 0); mRemaining = burst_len;
        mFinal = (burst_len == 1); mStopReq = 0;
      end
    end else begin
      if (mFree && !mFinal && stop) mStopReq = 1;
      if (hs) begin
        mState = lfsrNext(mState);
        if (mFinal) begin
          mActive = 0; mFinal = 0; mStopReq = 0; mDone = 1;
        end else if (mFree) begin
          mFinal = mStopReq;
        end else begin
          mRemaining--;
          mFinal = (mRemaining == 1);
        end
      end
    end
  endtask

  // Drive one cycle of inputs, log any accepted beat, clock, then compare all outputs.
  task automatic applyStimulus(input logic r, input logic sl, input logic [7:0] sin,
                               input logic st, input logic [15:0] len,
                               input logic sp, input logic rdy);
    reset = r; seed_load = sl; seed_in = sin; start = st;
    burst_len = len; stop = sp; m_tready = rdy;
    if (!r && m_tvalid && m_tready) beats.push_back({m_tlast, m_tdata});
    modelUpdate();
    @(posedge clk);
    #1;
    checkOutput("data",  m_tdata,  mState);
    checkOutput("valid", m_tvalid, mActive);
    checkOutput("last",  m_tlast,  mFinal);
    checkOutput("busy",  busy,     mActive);
    checkOutput("done",  done,     mDone);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 0, 16'd0, 0, 1);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 8'h00, 0, 16'd0, 0, 1);
  endtask

  task automatic runUntilIdle(input int maxCyc);
    int n;
    n = 0;
    while (busy && n < maxCyc) begin
      applyStimulus(0, 0, 8'h00, 0, 16'd0, 0, 1);
      n++;
    end
    checkOutput("idle_reached", busy, 1'b0);
  endtask

  task automatic checkBeats(input string tag);
    checkOutput({tag, "_count"}, beats.size(), expBeats.size());
    for (int i = 0; i < expBeats.size() && i < beats.size(); i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), beats[i], expBeats[i]);
  endtask

  initial begin
    int seen[256];
    int lastCount;

    // Reset, including one cycle where start/seed_load are also high.
    doReset();
    applyStimulus(1, 1, 8'h55, 1, 16'd6, 0, 1);
    checkOutput("rst_data",  m_tdata,  8'h01);
    checkOutput("rst_valid", m_tvalid, 1'b0);

    // Six-beat burst from the reset seed with ready held high.
    beats.delete();
    applyStimulus(0, 0, 8'h00, 1, 16'd6, 0, 1);
    idle(6);
    checkOutput("burst6_done", done, 1'b1);
    idle(1);
    expBeats = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h011, 9'h123};
    checkBeats("burst6");

    // Reset during beat 3 aborts the burst; the next burst restarts at 01.
    doReset();
    applyStimulus(0, 0, 8'h00, 1, 16'd6, 0, 1);
    idle(2);
    doReset();
    checkOutput("abort_valid", m_tvalid, 1'b0);
    idle(2);
    beats.delete();
    applyStimulus(0, 0, 8'h00, 1, 16'd2, 0, 1);
    idle(3);
    expBeats = '{9'h001, 9'h102};
    checkBeats("restart");

    // Three-cycle stall while 08 is presented.
    doReset();
    beats.delete();
    applyStimulus(0, 0, 8'h00, 1, 16'd6, 0, 1);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 16'd0, 0, 0);
      checkOutput("stall_data", m_tdata, 8'h08);
    end
    idle(4);
    expBeats = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h011, 9'h123};
    checkBeats("stall");

    // Zero seed load substitutes SEED; seed_load during RUN is ignored.
    beats.delete();
    applyStimulus(0, 1, 8'h00, 0, 16'd0, 0, 1);
    applyStimulus(0, 0, 8'h00, 1, 16'd2, 0, 1);
    applyStimulus(0, 1, 8'h77, 0, 16'd0, 0, 1);
    applyStimulus(0, 1, 8'h77, 0, 16'd0, 0, 1);
    idle(1);
    checkOutput("runload_ignored", m_tdata, 8'h04);
    expBeats = '{9'h001, 9'h102};
    checkBeats("zeroseed");

    // Seed load and start together with a one-beat burst.
    beats.delete();
    applyStimulus(0, 1, 8'h5A, 1, 16'd1, 0, 1);
    checkOutput("len1_tlast", m_tlast, 1'b1);
    idle(2);
    expBeats = '{9'h15A};
    checkBeats("len1");

    // Free run, stop while 04 is stalled, then a stop on the final beat is ignored.
    doReset();
    beats.delete();
    applyStimulus(0, 0, 8'h00, 1, 16'd0, 0, 1);
    idle(2);
    applyStimulus(0, 0, 8'h00, 0, 16'd0, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 16'd0, 0, 0);
    checkOutput("stop_stall_last", m_tlast, 1'b0);
    idle(1);
    checkOutput("stop_final_last", m_tlast, 1'b1);
    applyStimulus(0, 0, 8'h00, 0, 16'd0, 1, 0);
    idle(2);
    expBeats = '{9'h001, 9'h002, 9'h004, 9'h108};
    checkBeats("stop");

    // Free run over the full period: 255 distinct nonzero values, then 01 again.
    doReset();
    beats.delete();
    applyStimulus(0, 0, 8'h00, 1, 16'd0, 0, 1);
    idle(256);
    applyStimulus(0, 0, 8'h00, 0, 16'd0, 1, 1);
    runUntilIdle(10);
    checkOutput("period_count", beats.size(), 258);
    if (beats.size() >= 256) begin
      foreach (seen[v]) seen[v] = 0;
      for (int i = 0; i < 255; i++) seen[beats[i][7:0]]++;
      checkOutput("period_zero", seen[0], 0);
      for (int v = 1; v < 256; v++) checkOutput($sformatf("period_val%0h", v), seen[v], 1);
      checkOutput("period_wrap", beats[255][7:0], 8'h01);
    end

    // Longest counted burst completes with a single tlast on the last beat.
    doReset();
    beats.delete();
    applyStimulus(0, 0, 8'h00, 1, 16'hFFFF, 0, 1);
    runUntilIdle(70000);
    checkOutput("maxlen_count", beats.size(), 65535);
    lastCount = 0;
    foreach (beats[i]) if (beats[i][8]) lastCount++;
    checkOutput("maxlen_tlasts", lastCount, 1);
    if (beats.size() > 0) checkOutput("maxlen_lastflag", beats[beats.size()-1][8], 1'b1);

    // Random traffic against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 9) == 0),
                    (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255))),
                    ($urandom_range(0, 3) == 0),
                    16'($urandom_range(0, 5)),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) < 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
